// File: rtl/axis_pkt_source.sv
// AXI-Stream style 8-bit packet source: a start pulse launches a burst of
// packets with programmable length, payload pattern and inter-packet gap.
module axis_pkt_source #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int CNT_W  = 8,
   parameter int GAP_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic [CNT_W-1:0]  num_pkts,
   input  logic [DATA_W-1:0] seed,
   input  logic              mode,
   input  logic [GAP_W-1:0]  gap,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pkt_idx,
   output logic [1:0]        dbg_state
);

   // Handshake: a beat transfers on a rising edge where m_valid && m_ready.
   // m_valid is registered and never looks at m_ready combinationally; once
   // raised it stays up, with m_data/m_last frozen, until that beat transfers.

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic              mode_q, mode_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [CNT_W-1:0]  pkt_q, pkt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [DATA_W-1:0] pay_q, pay_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] nxt_pay;

   // pay_q holds the payload of the beat on the bus (or the next one during a gap)
   assign nxt_pay = mode_q ? pay_q : pay_q + DATA_W'(1);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      num_d     = num_q;
      mode_d    = mode_q;
      gap_d     = gap_q;
      beat_d    = beat_q;
      pkt_d     = pkt_q;
      gap_cnt_d = gap_cnt_q;
      pay_d     = pay_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            busy_d  = 1'b0;
            if (start) begin
               len_d   = pkt_len;
               num_d   = num_pkts;
               mode_d  = mode;
               gap_d   = gap;
               beat_d  = '0;
               pkt_d   = '0;
               pay_d   = seed;
               data_d  = seed;
               valid_d = 1'b1;
               last_d  = (pkt_len == '0);
               busy_d  = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (valid_q && m_ready) begin
               pay_d = nxt_pay;
               if (beat_q == len_q) begin
                  if (pkt_q == num_q) begin
                     state_d = S_IDLE;
                     valid_d = 1'b0;
                     last_d  = 1'b0;
                     data_d  = '0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pkt_d   = '0;
                  end else if (gap_q != '0) begin
                     state_d   = S_GAP;
                     gap_cnt_d = gap_q;
                     valid_d   = 1'b0;
                     last_d    = 1'b0;
                     data_d    = '0;
                  end else begin
                     beat_d = '0;
                     pkt_d  = pkt_q + CNT_W'(1);
                     data_d = nxt_pay;
                     last_d = (len_q == '0);
                  end
               end else begin
                  beat_d = beat_q + LEN_W'(1);
                  data_d = nxt_pay;
                  last_d = ((beat_q + LEN_W'(1)) == len_q);
               end
            end
         end
         S_GAP: begin
            // The last idle cycle raises valid so the bus is low exactly gap cycles
            if (gap_cnt_q == GAP_W'(1)) begin
               state_d = S_SEND;
               beat_d  = '0;
               pkt_d   = pkt_q + CNT_W'(1);
               valid_d = 1'b1;
               data_d  = pay_q;
               last_d  = (len_q == '0);
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         num_q     <= '0;
         mode_q    <= 1'b0;
         gap_q     <= '0;
         beat_q    <= '0;
         pkt_q     <= '0;
         gap_cnt_q <= '0;
         pay_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         num_q     <= num_d;
         mode_q    <= mode_d;
         gap_q     <= gap_d;
         beat_q    <= beat_d;
         pkt_q     <= pkt_d;
         gap_cnt_q <= gap_cnt_d;
         pay_q     <= pay_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign m_data    = data_q;
   assign m_valid   = valid_q;
   assign m_last    = last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pkt_idx   = pkt_q;
   assign dbg_state = state_q;

endmodule
